// File: rtl/decade_counter_chain.sv
// Multi-digit modulo-MODULUS up/down counter with parallel load, terminal
// count and wrap pulse. Each digit counts 0..MODULUS-1. A digit steps only
// when every lower digit sits at its rollover value for the current direction.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high (count = 0, wrap = 0)
//   en        count enable, one step per clock while high
//   up        direction: 1 = increment, 0 = decrement
//   load      parallel load strobe (beats en, loses to rst)
//   load_val  load value, digit i in [i*DW +: DW], clamped to MODULUS-1
//   count     current value, digit 0 (least significant) in [DW-1:0]
//   tc        terminal count, combinational from en, up and count
//   wrap      registered one-cycle pulse after a full rollover
module decade_counter_chain #(
  parameter int unsigned DIGITS  = 2,
  parameter int unsigned MODULUS = 10,
  parameter int unsigned DW      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 up,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 wrap
);

  localparam logic [DW-1:0] DIGIT_MAX = DW'(MODULUS - 1);

  logic [DW-1:0] dig_q    [DIGITS];
  logic [DW-1:0] dig_step [DIGITS];
  logic [DW-1:0] dig_load [DIGITS];
  logic          all_edge;

  // Per-digit step values; the enable chain ripples through digits sitting
  // at their rollover value (max when counting up, zero when counting down).
  always_comb begin : step_logic
    logic chain;
    chain = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig_step[i] = dig_q[i];
      if (chain) begin
        if (up) begin
          dig_step[i] = (dig_q[i] == DIGIT_MAX) ? '0 : dig_q[i] + DW'(1);
        end else begin
          dig_step[i] = (dig_q[i] == '0) ? DIGIT_MAX : dig_q[i] - DW'(1);
        end
      end
      chain = chain & (up ? (dig_q[i] == DIGIT_MAX) : (dig_q[i] == '0));
    end
    all_edge = chain;
  end

  // Load fields clamped into the legal digit range.
  always_comb begin : load_clamp
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig_load[i] = load_val[i*DW +: DW];
      if (load_val[i*DW +: DW] > DIGIT_MAX) begin
        dig_load[i] = DIGIT_MAX;
      end
    end
  end

  assign tc = en & all_edge;

  // Digit registers and wrap pulse; priority rst > load > en.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig_q[i] <= '0;
      end
      wrap <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < int'(DIGITS); i++) begin
        dig_q[i] <= dig_load[i];
      end
      wrap <= 1'b0;
    end else begin
      if (en) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          dig_q[i] <= dig_step[i];
        end
      end
      wrap <= tc;
    end
  end

  // Pack digits onto the output bus.
  always_comb begin : pack
    count = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      count[i*DW +: DW] = dig_q[i];
    end
  end

endmodule
